// File: rtl/regfile_param.sv
// regfile_param: one-write / two-read register file for the decode stage.
// Provides write-to-read bypass, a per-register pending-write scoreboard and
// a multi-cycle clear-all sequencer that zeroes one register per cycle.
module regfile_param #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] SrcReg1,
   input  logic [ADDR_W-1:0] SrcReg2,
   output logic [DATA_W-1:0] SrcData1,
   output logic [DATA_W-1:0] SrcData2,
   input  logic [ADDR_W-1:0] DstReg,
   input  logic [DATA_W-1:0] DstData,
   input  logic              WriteReg,
   input  logic              IssueEn,
   input  logic [ADDR_W-1:0] IssueReg,
   output logic              Busy1,
   output logic              Busy2,
   input  logic              ClrReq,
   output logic              ClrBusy
);

   localparam int NUM_REGS = 2**ADDR_W;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [NUM_REGS-1:0] pending;
   logic [NUM_REGS-1:0] pend_next;
   logic [0:0]          state;
   logic [ADDR_W-1:0]   clr_cnt;

   logic                idle;
   logic                clr_start;
   logic                wr_ok;
   logic                iss_ok;
   logic                hit1;
   logic                hit2;

   // Write wordline: ADDR_W cascaded conditional shifts, stage k shifts by 2**k.
   logic [NUM_REGS-1:0] wl_stage [ADDR_W+1];
   logic [NUM_REGS-1:0] wordline;

   assign wl_stage[0] = {{(NUM_REGS-1){1'b0}}, 1'b1};

   for (genvar k = 0; k < ADDR_W; k++) begin : g_dec
      assign wl_stage[k+1] = DstReg[k] ? (wl_stage[k] << (2**k)) : wl_stage[k];
   end

   assign wordline = wl_stage[ADDR_W];

   // A write or issue coinciding with the start of a clear is dropped.
   assign idle      = (state == ST_IDLE);
   assign clr_start = idle && ClrReq;
   assign wr_ok     = WriteReg && idle && !ClrReq &&
                      !((ZERO_REG != 0) && (DstReg == '0));
   assign iss_ok    = IssueEn && idle && !ClrReq &&
                      !((ZERO_REG != 0) && (IssueReg == '0));
   assign hit1      = (BYPASS != 0) && wr_ok && (DstReg == SrcReg1);
   assign hit2      = (BYPASS != 0) && wr_ok && (DstReg == SrcReg2);
   assign ClrBusy   = (state == ST_CLEAR);

   // Read muxes: zero register, then same-cycle bypass override.
   always_comb begin
      SrcData1 = regs[SrcReg1];
      if ((ZERO_REG != 0) && (SrcReg1 == '0)) SrcData1 = '0;
      if (hit1) SrcData1 = DstData;
      SrcData2 = regs[SrcReg2];
      if ((ZERO_REG != 0) && (SrcReg2 == '0)) SrcData2 = '0;
      if (hit2) SrcData2 = DstData;
   end

   // Busy hides pending bits satisfied by bypass and is forced low while clearing.
   assign Busy1 = pending[SrcReg1] && !hit1 && !ClrBusy;
   assign Busy2 = pending[SrcReg2] && !hit2 && !ClrBusy;

   // Next scoreboard value: write clears first so an issue to the same register wins.
   always_comb begin
      pend_next = pending;
      if (wr_ok)  pend_next[DstReg]   = 1'b0;
      if (iss_ok) pend_next[IssueReg] = 1'b1;
   end

   // Scoreboard register; entering a clear wipes every pending bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else if (clr_start) begin
         pending <= '0;
      end else begin
         pending <= pend_next;
      end
   end

   // Clear sequencer: one register zeroed per cycle, counter wraps back to 0 on exit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         clr_cnt <= '0;
      end else if (state == ST_CLEAR) begin
         clr_cnt <= clr_cnt + ADDR_W'(1);
         if (clr_cnt == ADDR_W'(NUM_REGS - 1)) state <= ST_IDLE;
      end else if (ClrReq) begin
         state   <= ST_CLEAR;
         clr_cnt <= '0;
      end
   end

   // Storage: cleared by the sequencer, otherwise written through the wordline.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (state == ST_CLEAR) begin
         regs[clr_cnt] <= '0;
      end else if (wr_ok) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wordline[i]) regs[i] <= DstData;
         end
      end
   end

endmodule

// File: tb/tb_regfile_param.sv
// Bench for regfile_param: directed table, clear/reset sequences, decoder
// sweeps on 16- and 32-entry builds, and randomized traffic against a model.
module tb_regfile_param;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  SrcReg1, SrcReg2, DstReg, IssueReg;
   logic [15:0] DstData;
   logic        WriteReg, IssueEn, ClrReq;
   logic [15:0] SrcData1, SrcData2, nb_SrcData1, nb_SrcData2;
   logic        Busy1, Busy2, ClrBusy, nb_Busy1, nb_Busy2, nb_ClrBusy;

   logic [4:0]  s1_32, s2_32, dst_32, ireg_32;
   logic [31:0] data_32, sd1_32, sd2_32;
   logic        wr_32, iss_32, clr_32, b1_32, b2_32, cb_32;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [15:0] m_regs [16];
   bit          m_pend [16];
   bit          clearing;
   int          clr_idx;

   always #5 clk = ~clk;

   regfile_param dut (
      .clk(clk), .rst_n(rst_n), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
      .SrcData1(SrcData1), .SrcData2(SrcData2), .DstReg(DstReg), .DstData(DstData),
      .WriteReg(WriteReg), .IssueEn(IssueEn), .IssueReg(IssueReg),
      .Busy1(Busy1), .Busy2(Busy2), .ClrReq(ClrReq), .ClrBusy(ClrBusy));

   regfile_param #(.BYPASS(0)) dut_nb (
      .clk(clk), .rst_n(rst_n), .SrcReg1(SrcReg1), .SrcReg2(SrcReg2),
      .SrcData1(nb_SrcData1), .SrcData2(nb_SrcData2), .DstReg(DstReg), .DstData(DstData),
      .WriteReg(WriteReg), .IssueEn(IssueEn), .IssueReg(IssueReg),
      .Busy1(nb_Busy1), .Busy2(nb_Busy2), .ClrReq(ClrReq), .ClrBusy(nb_ClrBusy));

   regfile_param #(.DATA_W(32), .ADDR_W(5)) dut32 (
      .clk(clk), .rst_n(rst_n), .SrcReg1(s1_32), .SrcReg2(s2_32),
      .SrcData1(sd1_32), .SrcData2(sd2_32), .DstReg(dst_32), .DstData(data_32),
      .WriteReg(wr_32), .IssueEn(iss_32), .IssueReg(ireg_32),
      .Busy1(b1_32), .Busy2(b2_32), .ClrReq(clr_32), .ClrBusy(cb_32));

   typedef struct {
      logic        wr;
      logic [3:0]  dst;
      logic [15:0] data;
      logic [3:0]  s1;
      logic [3:0]  s2;
      logic        iss;
      logic [3:0]  ireg;
      logic [15:0] e1;
      logic [15:0] e2;
      logic        eb1;
      logic        eb2;
   } vec_t;

   vec_t tbl [14];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] rd(input logic [3:0] src);
      return (src == 4'd0) ? 16'h0 : m_regs[src];
   endfunction

   function automatic bit wr_accept();
      return WriteReg && !clearing && !ClrReq && (DstReg != 4'd0);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      clearing = 1'b0;
      clr_idx  = 0;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic model_tick();
      if (clearing) begin
         m_regs[clr_idx] = '0;
         clr_idx++;
         if (clr_idx == 16) begin
            clearing = 1'b0;
            clr_idx  = 0;
         end
      end else if (ClrReq) begin
         clearing = 1'b1;
         clr_idx  = 0;
         for (int i = 0; i < 16; i++) m_pend[i] = 1'b0;
      end else begin
         if (wr_accept()) begin
            m_regs[DstReg] = DstData;
            m_pend[DstReg] = 1'b0;
         end
         if (IssueEn && IssueReg != 4'd0) m_pend[IssueReg] = 1'b1;
      end
   endtask

   task automatic compare_all(input string tag);
      bit h1, h2;
      h1 = wr_accept() && (DstReg == SrcReg1);
      h2 = wr_accept() && (DstReg == SrcReg2);
      check({tag, ".d1"}, SrcData1, h1 ? DstData : rd(SrcReg1));
      check({tag, ".d2"}, SrcData2, h2 ? DstData : rd(SrcReg2));
      check({tag, ".b1"}, Busy1, !clearing && m_pend[SrcReg1] && !h1);
      check({tag, ".b2"}, Busy2, !clearing && m_pend[SrcReg2] && !h2);
      check({tag, ".clrbusy"}, ClrBusy, clearing);
      check({tag, ".nb_d1"}, nb_SrcData1, rd(SrcReg1));
      check({tag, ".nb_b1"}, nb_Busy1, !clearing && m_pend[SrcReg1]);
   endtask

   // Called just after a falling edge with inputs applied.
   task automatic step(input string tag);
      #1;
      compare_all(tag);
      @(posedge clk);
      model_tick();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      WriteReg = 1'b0; IssueEn = 1'b0; ClrReq = 1'b0;
      DstReg = '0; DstData = '0; IssueReg = '0;
      SrcReg1 = '0; SrcReg2 = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int busy_cycles;
      tbl[0]  = '{1'b1, 4'd5, 16'hBEEF, 4'd5, 4'd5, 1'b0, 4'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
      tbl[1]  = '{1'b0, 4'd0, 16'h0000, 4'd5, 4'd5, 1'b0, 4'd0, 16'hBEEF, 16'hBEEF, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 4'd0, 16'h1234, 4'd0, 4'd5, 1'b0, 4'd0, 16'h0000, 16'hBEEF, 1'b0, 1'b0};
      tbl[3]  = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 4'd3, 16'hA5A5, 4'd3, 4'd5, 1'b0, 4'd0, 16'hA5A5, 16'hBEEF, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd3, 1'b1, 4'd7, 16'h0000, 16'hA5A5, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd3, 1'b0, 4'd0, 16'h0000, 16'hA5A5, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 4'd7, 16'h1111, 4'd7, 4'd5, 1'b0, 4'd0, 16'h1111, 16'hBEEF, 1'b0, 1'b0};
      tbl[8]  = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd7, 1'b0, 4'd0, 16'h1111, 16'h1111, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 4'd7, 16'h2222, 4'd7, 4'd7, 1'b1, 4'd7, 16'h2222, 16'h2222, 1'b0, 1'b0};
      tbl[10] = '{1'b0, 4'd0, 16'h0000, 4'd7, 4'd3, 1'b0, 4'd0, 16'h2222, 16'hA5A5, 1'b1, 1'b0};
      tbl[11] = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd7, 1'b1, 4'd0, 16'h0000, 16'h2222, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 4'd0, 16'h0000, 4'd0, 4'd0, 1'b0, 4'd0, 16'h0000, 16'h0000, 1'b0, 1'b0};
      tbl[13] = '{1'b1, 4'd7, 16'h3333, 4'd3, 4'd7, 1'b0, 4'd0, 16'hA5A5, 16'h3333, 1'b0, 1'b0};

      idle_inputs();
      wr_32 = 0; iss_32 = 0; clr_32 = 0; dst_32 = '0; ireg_32 = '0;
      data_32 = '0; s1_32 = '0; s2_32 = '0;
      model_reset();

      // Reset state
      rst_n = 1'b0;
      SrcReg1 = 4'd5; SrcReg2 = 4'd9;
      @(negedge clk); @(negedge clk);
      #1;
      check("reset.d1", SrcData1, 16'h0);
      check("reset.d2", SrcData2, 16'h0);
      check("reset.b1", Busy1, 1'b0);
      check("reset.clrbusy", ClrBusy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 14; i++) begin
         WriteReg = tbl[i].wr;  DstReg = tbl[i].dst; DstData = tbl[i].data;
         SrcReg1 = tbl[i].s1;   SrcReg2 = tbl[i].s2;
         IssueEn = tbl[i].iss;  IssueReg = tbl[i].ireg;
         #1;
         check($sformatf("tbl%0d.d1", i), SrcData1, tbl[i].e1);
         check($sformatf("tbl%0d.d2", i), SrcData2, tbl[i].e2);
         check($sformatf("tbl%0d.b1", i), Busy1, tbl[i].eb1);
         check($sformatf("tbl%0d.b2", i), Busy2, tbl[i].eb2);
         step($sformatf("tbl%0d", i));
      end
      idle_inputs();

      // No-bypass build: old value same cycle, new value next cycle
      WriteReg = 1'b1; DstReg = 4'd3; DstData = 16'h5A5A; SrcReg1 = 4'd3;
      #1;
      check("nobyp.same", nb_SrcData1, 16'hA5A5);
      step("nobyp.w");
      idle_inputs(); SrcReg1 = 4'd3;
      #1;
      check("nobyp.next", nb_SrcData1, 16'h5A5A);
      step("nobyp.r");

      // Fill all registers, leave r4 pending, then clear
      for (int i = 0; i < 16; i++) begin
         WriteReg = 1'b1; DstReg = 4'(i); DstData = 16'($urandom);
         IssueEn = (i == 4); IssueReg = 4'd4;
         SrcReg1 = 4'(i); SrcReg2 = 4'(15 - i);
         step("fill");
      end
      idle_inputs();
      ClrReq = 1'b1; SrcReg1 = 4'd4;
      step("clr.start");
      ClrReq = 1'b0;
      busy_cycles = 0;
      for (int c = 0; c < 20; c++) begin
         WriteReg = (c == 3); DstReg = 4'd2; DstData = 16'hFFFF;
         SrcReg1 = 4'(c); SrcReg2 = 4'd2;
         #1;
         if (ClrBusy) busy_cycles++;
         step("clr.run");
      end
      check("clr.busy_cycles", 64'(busy_cycles), 64'd16);
      idle_inputs();
      for (int i = 0; i < 16; i++) begin
         SrcReg1 = 4'(i); SrcReg2 = 4'(15 - i);
         #1;
         check($sformatf("clr.zero%0d", i), SrcData1, 16'h0);
         check($sformatf("clr.busy%0d", i), Busy1, 1'b0);
         step("clr.after");
      end

      // Async reset in the middle of a clear
      WriteReg = 1'b1; DstReg = 4'd9; DstData = 16'h9999; IssueEn = 1'b1; IssueReg = 4'd11;
      step("rstclr.w");
      idle_inputs();
      ClrReq = 1'b1;
      step("rstclr.start");
      ClrReq = 1'b0;
      for (int c = 0; c < 6; c++) step("rstclr.run");
      SrcReg1 = 4'd9;
      #1;
      check("rstclr.pre_d1", SrcData1, 16'h9999);
      check("rstclr.pre_busy", ClrBusy, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("rstclr.clrbusy", ClrBusy, 1'b0);
      check("rstclr.d1", SrcData1, 16'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      SrcReg1 = 4'd11;
      step("rstclr.idle");

      // Wordline sweeps
      for (int d = 0; d < 16; d++) begin
         DstReg = 4'(d);
         #1;
         check($sformatf("wl16.%0d", d), 64'(dut.wordline), 64'd1 << d);
      end
      DstReg = '0;
      for (int d = 0; d < 32; d++) begin
         dst_32 = 5'(d);
         #1;
         check($sformatf("wl32.%0d", d), 64'(dut32.wordline), 64'd1 << d);
      end

      // 32-entry build read/write
      @(negedge clk);
      wr_32 = 1'b1; dst_32 = 5'd31; data_32 = 32'hDEADBEEF; s1_32 = 5'd31; s2_32 = 5'd16;
      #1;
      check("w32.bypass", sd1_32, 32'hDEADBEEF);
      step("w32.a");
      dst_32 = 5'd0; data_32 = 32'h12345678;
      step("w32.b");
      wr_32 = 1'b0; s1_32 = 5'd0;
      #1;
      check("w32.r31", sd2_32, 32'h0);
      check("w32.zero", sd1_32, 32'h0);
      s1_32 = 5'd31;
      #1;
      check("w32.read", sd1_32, 32'hDEADBEEF);
      step("w32.c");

      // Randomized traffic against the model
      for (int n = 0; n < 400; n++) begin
         WriteReg = 1'($urandom);
         DstReg   = 4'($urandom);
         DstData  = 16'($urandom);
         IssueEn  = ($urandom_range(0, 2) == 0);
         IssueReg = 4'($urandom);
         ClrReq   = ($urandom_range(0, 49) == 0);
         SrcReg1  = ($urandom_range(0, 3) == 0) ? DstReg : 4'($urandom);
         SrcReg2  = 4'($urandom);
         step("rand");
      end
      idle_inputs();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
